// File: rtl/chunked_add_sub.sv
// Multi-cycle adder/subtractor: processes CHUNK bits per clock, LSB chunk first.
// Result doubles as the accumulator for the accumulate modes.
module chunked_add_sub #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic [1:0]       Mode,
  input  logic [WIDTH-1:0] OpX,
  input  logic [WIDTH-1:0] OpY,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] Result,
  output logic             CarryOut,
  output logic             Overflow,
  output logic             Zero,
  output logic [1:0]       fsm_state
);

  localparam int N  = WIDTH / CHUNK;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]             state;
  logic [CW-1:0]          cnt;
  logic [WIDTH-1:0]       a_reg;
  logic [WIDTH-1:0]       b_reg;
  logic [WIDTH-1:0]       sum_reg;
  logic                   carry;
  logic [CHUNK:0]         chunk_sum;
  logic [WIDTH+CHUNK-1:0] sum_ext;
  logic [WIDTH-1:0]       new_result;
  logic                   last;
  logic                   msb_overflow;

  // Operands shift right each cycle so the active chunk is always at bit 0;
  // the sum shifts in from the top and is complete after N steps.
  assign chunk_sum  = {1'b0, a_reg[CHUNK-1:0]} + {1'b0, b_reg[CHUNK-1:0]}
                    + {{CHUNK{1'b0}}, carry};
  assign sum_ext    = {chunk_sum[CHUNK-1:0], sum_reg};
  assign new_result = sum_ext[WIDTH+CHUNK-1:CHUNK];
  assign last       = (cnt == CW'(N - 1));

  // a^b^sum at the MSB recovers the carry into the MSB.
  assign msb_overflow = a_reg[CHUNK-1] ^ b_reg[CHUNK-1] ^ chunk_sum[CHUNK-1]
                      ^ chunk_sum[CHUNK];

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state    <= IDLE;
      cnt      <= '0;
      a_reg    <= '0;
      b_reg    <= '0;
      sum_reg  <= '0;
      carry    <= 1'b0;
      Result   <= '0;
      CarryOut <= 1'b0;
      Overflow <= 1'b0;
      Zero     <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (Start) begin
            a_reg <= Mode[1] ? Result : OpX;
            b_reg <= OpY ^ {WIDTH{Mode[0]}};
            carry <= Mode[0];
            cnt   <= '0;
            state <= RUN;
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          a_reg   <= a_reg >> CHUNK;
          b_reg   <= b_reg >> CHUNK;
          sum_reg <= new_result;
          carry   <= chunk_sum[CHUNK];
          cnt     <= cnt + CW'(1);
          if (last) begin
            Result   <= new_result;
            CarryOut <= chunk_sum[CHUNK];
            Overflow <= msb_overflow;
            Zero     <= (new_result == '0);
            state    <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign Busy      = (state == RUN);
  assign Done      = (state == DONE);
  assign fsm_state = state;

endmodule

// File: tb/tb_chunked_add_sub.sv
// Self-checking bench for chunked_add_sub: directed scenarios with literal
// expectations plus randomized traffic against a behavioural model.
module tb_chunked_add_sub;

  localparam int WIDTH = 16;
  localparam int CHUNK = 4;
  localparam int N     = WIDTH / CHUNK;

  // ---------------- clock / reset ----------------
  logic             Clk = 1'b0;
  logic             Reset = 1'b0;
  logic             Start = 1'b0;
  logic [1:0]       Mode = 2'b00;
  logic [WIDTH-1:0] OpX = '0;
  logic [WIDTH-1:0] OpY = '0;
  logic             Busy, Done, CarryOut, Overflow, Zero;
  logic [WIDTH-1:0] Result;
  logic [1:0]       fsm_state;

  always #5 Clk = ~Clk;

  chunked_add_sub #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .Mode(Mode), .OpX(OpX), .OpY(OpY),
    .Busy(Busy), .Done(Done), .Result(Result), .CarryOut(CarryOut),
    .Overflow(Overflow), .Zero(Zero), .fsm_state(fsm_state)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [WIDTH-1:0] exp_q[$];
  int               m_left = 0;
  logic             m_done = 1'b0;
  logic [WIDTH-1:0] m_result = '0;
  logic             m_c = 1'b0, m_v = 1'b0, m_z = 1'b0;
  logic             p_c, p_v;

  function automatic void model_calc(input logic [1:0] md, input logic [WIDTH-1:0] a,
                                     input logic [WIDTH-1:0] y, output logic [WIDTH-1:0] r,
                                     output logic c, output logic v);
    if (!md[0]) begin
      {c, r} = {1'b0, a} + {1'b0, y};
      v = (a[WIDTH-1] == y[WIDTH-1]) && (r[WIDTH-1] != a[WIDTH-1]);
    end else begin
      r = a - y;
      c = (a >= y);
      v = (a[WIDTH-1] != y[WIDTH-1]) && (r[WIDTH-1] != a[WIDTH-1]);
    end
  endfunction

  always @(posedge Clk or posedge Reset) begin
    logic [WIDTH-1:0] r;
    if (Reset) begin
      m_left = 0; m_done = 1'b0; m_result = '0;
      m_c = 1'b0; m_v = 1'b0; m_z = 1'b0;
      exp_q.delete();
    end else begin
      m_done = 1'b0;
      if (m_left > 0) begin
        m_left--;
        if (m_left == 0) begin
          m_result = exp_q.pop_front();
          m_c = p_c; m_v = p_v; m_z = (m_result == '0);
          m_done = 1'b1;
        end
      end else if (Start) begin
        model_calc(Mode, Mode[1] ? m_result : OpX, OpY, r, p_c, p_v);
        exp_q.push_back(r);
        m_left = N;
      end
    end
  end

  // ---------------- scoreboard compare ----------------
  always @(negedge Clk) begin
    chk("busy", Busy, m_left > 0);
    chk("done", Done, m_done);
    chk("result", Result, m_result);
    chk("carry", CarryOut, m_c);
    chk("overflow", Overflow, m_v);
    chk("zero", Zero, m_z);
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(negedge Clk);
    #1;
  endtask

  // Start is raised now; the following edge captures the operation.
  task automatic run_op(input string name, input logic [1:0] md, input logic [WIDTH-1:0] x,
                        input logic [WIDTH-1:0] y, input logic [WIDTH-1:0] er,
                        input logic ec, input logic ev, input logic ez, input bit inject);
    int k = 0;
    int busy_n = 0;
    bit seen = 0;
    Start = 1'b1; Mode = md; OpX = x; OpY = y;
    for (int i = 1; i <= 20 && !seen; i++) begin
      tick();
      if (i == 1) begin
        Start = 1'b0;
        OpX = 16'(~x); OpY = 16'(~y); Mode = ~md;
      end
      if (inject && i == 2) begin
        Start = 1'b1; Mode = 2'(~md); OpX = 16'($urandom); OpY = 16'($urandom);
      end
      if (inject && i == 4) Start = 1'b0;
      if (Busy) busy_n++;
      if (Done) begin
        seen = 1;
        k = i;
      end
    end
    chk({name, "_latency"}, k, N + 1);
    chk({name, "_busy_cycles"}, busy_n, N);
    chk({name, "_res"}, Result, er);
    chk({name, "_c"}, CarryOut, ec);
    chk({name, "_v"}, Overflow, ev);
    chk({name, "_z"}, Zero, ez);
    chk({name, "_model"}, m_result, er);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int pos[3];
    logic [WIDTH-1:0] res[3];
    int dn;

    #1 Reset = 1'b1;
    tick();
    tick();
    chk("reset_busy", Busy, 1'b0);
    chk("reset_done", Done, 1'b0);
    chk("reset_result", Result, 16'h0000);
    chk("reset_zero", Zero, 1'b0);
    Reset = 1'b0;

    run_op("add", 2'b00, 16'h1234, 16'h0FFF, 16'h2233, 1'b0, 1'b0, 1'b0, 0);
    tick();
    run_op("sub_neg", 2'b01, 16'h0005, 16'h0007, 16'hFFFE, 1'b0, 1'b0, 1'b0, 0);
    tick();
    run_op("sub_zero", 2'b01, 16'h1234, 16'h1234, 16'h0000, 1'b1, 1'b0, 1'b1, 0);
    tick();
    run_op("add_ovf", 2'b00, 16'h7FFF, 16'h0001, 16'h8000, 1'b0, 1'b1, 1'b0, 0);
    tick();
    run_op("sub_ovf", 2'b01, 16'h8000, 16'h0001, 16'h7FFF, 1'b1, 1'b1, 1'b0, 0);

    // Abort an operation with reset two cycles after its start edge.
    tick();
    Start = 1'b1; Mode = 2'b00; OpX = 16'h1111; OpY = 16'h2222;
    tick();
    Start = 1'b0;
    tick();
    Reset = 1'b1;
    #1;
    chk("abort_busy", Busy, 1'b0);
    chk("abort_done", Done, 1'b0);
    chk("abort_result", Result, 16'h0000);
    chk("abort_c", CarryOut, 1'b0);
    chk("abort_v", Overflow, 1'b0);
    chk("abort_z", Zero, 1'b0);
    tick();
    tick();
    Reset = 1'b0;
    run_op("post_reset", 2'b00, 16'h0001, 16'h0001, 16'h0002, 1'b0, 1'b0, 1'b0, 0);

    // Back-to-back accumulate with Start held high.
    tick();
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    Start = 1'b1; Mode = 2'b10; OpX = 16'hBEEF; OpY = 16'h0003;
    dn = 0;
    for (int i = 1; i <= 40 && dn < 3; i++) begin
      tick();
      if (Done) begin
        pos[dn] = i;
        res[dn] = Result;
        dn++;
        if (dn == 3) Start = 1'b0;
      end
    end
    Start = 1'b0;
    chk("acc_count", dn, 3);
    chk("acc_first_pos", pos[0], N + 1);
    chk("acc_r0", res[0], 16'd3);
    chk("acc_r1", res[1], 16'd6);
    chk("acc_r2", res[2], 16'd9);
    chk("acc_gap1", pos[1] - pos[0], N + 1);
    chk("acc_gap2", pos[2] - pos[1], N + 1);
    tick();
    run_op("acc_sub", 2'b11, 16'h5555, 16'h0009, 16'h0000, 1'b1, 1'b0, 1'b1, 0);

    // Start during RUN with different operands must be ignored.
    tick();
    run_op("ignore", 2'b00, 16'h4321, 16'h1111, 16'h5432, 1'b0, 1'b0, 1'b0, 1);
    tick();
    tick();

    // Randomized traffic, checked every cycle by the scoreboard.
    for (int i = 0; i < 3000; i++) begin
      tick();
      Start = ($urandom_range(0, 2) == 0);
      Mode  = 2'($urandom);
      case ($urandom_range(0, 7))
        0: OpX = 16'h7FFF;
        1: OpX = 16'h8000;
        2: OpX = 16'hFFFF;
        default: OpX = 16'($urandom);
      endcase
      case ($urandom_range(0, 7))
        0: OpY = 16'h0000;
        1: OpY = 16'h0001;
        2: OpY = 16'h8000;
        default: OpY = 16'($urandom);
      endcase
      Reset = ($urandom_range(0, 249) == 0);
    end
    Start = 1'b0;
    Reset = 1'b0;
    for (int i = 0; i < 10; i++) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
